// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access stage.
// Holds the one-hot opcode layout, exception bit indices, load/store funct3 codes,
// the stage FSM encoding and helpers for lane offset and misalignment detection.
package mem_access_pkg;

   // One-hot opcode vector from execute; only the bits this stage inspects are named.
   localparam int OPCODE_WIDTH = 11;
   localparam int OP_ALU       = 0;
   localparam int OP_LOAD      = 2;
   localparam int OP_STORE     = 3;

   // Exception vector layout; the two misalignment bits are raised by this stage.
   localparam int EXCEPTION_WIDTH       = 6;
   localparam int LOAD_ADDR_MISALIGNED  = 4;
   localparam int STORE_ADDR_MISALIGNED = 5;

   // Load/store funct3 codes. Bits [1:0] give the size, bit 2 selects zero extension.
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   // Byte offset inside the word after dropping low bits that the access width ignores.
   function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   return a;
         2'b01:   return {a[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   return 1'b0;
         2'b01:   return a[0];
         default: return (a != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/ack port of the memory-access stage.
// Ports: dmem_req/we/addr/wdata/sel driven by the stage (master), dmem_ack/rdata by memory.
// The request stays asserted with stable payload until a single-cycle ack.
interface mem_access_if #(
   parameter int DMEM_AW = 32
) ();
   logic               dmem_req;
   logic               dmem_we;
   logic [DMEM_AW-1:0] dmem_addr;
   logic [31:0]        dmem_wdata;
   logic [3:0]         dmem_sel;
   logic               dmem_ack;
   logic [31:0]        dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_sel,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_sel,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_access_lane_align.sv
// mem_lane_align: byte-lane steering for stores and extract/extend for loads; purely combinational.
// Ports: i_funct3/i_off select size and lane, i_rs2 store data, i_rdata load word;
// o_sel byte enables, o_wdata replicated store data, o_ldata extended load result.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_rs2,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_sel,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ldata
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_off)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_sel   = 4'b1111;
      o_wdata = i_rs2;
      o_ldata = i_rdata;
      case (i_funct3)
         LB, LBU: begin
            o_sel   = 4'b0001 << i_off;
            o_wdata = {4{i_rs2[7:0]}};
            o_ldata = i_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         LH, LHU: begin
            o_sel   = 4'b0011 << {i_off[1], 1'b0};
            o_wdata = {2{i_rs2[15:0]}};
            o_ldata = i_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_access.sv
// mem_access: pipeline stage between execute and writeback; loads/stores run one request/ack
// bus cycle, everything else passes through in one cycle. Optional macro MEM_MISALIGN_TRAP_EN
// traps misaligned accesses instead of forcing alignment. Ports: prev_* from execute, stage outputs
// to writeback, dmem interface (master), stall/flush/clk_en pipeline control.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int DMEM_AW = 32
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [OPCODE_WIDTH-1:0]    prev_opcode_type,
   input  logic [2:0]                 prev_funct3,
   input  logic [31:0]                prev_alu_result,
   input  logic [31:0]                prev_rs2_data,
   input  logic [4:0]                 prev_rd,
   input  logic [31:0]                prev_rd_wdata,
   input  logic                       prev_rd_w_en,
   input  logic                       prev_rd_valid,
   input  logic [EXCEPTION_WIDTH-1:0] prev_exception,
   input  logic [31:0]                prev_pc,
   output logic [4:0]                 rd,
   output logic [31:0]                rd_wdata,
   output logic                       rd_w_en,
   output logic                       rd_valid,
   output logic [EXCEPTION_WIDTH-1:0] exception,
   output logic [OPCODE_WIDTH-1:0]    opcode_type,
   output logic [2:0]                 funct3,
   output logic [31:0]                pc,
   mem_access_if.master               dmem,
   input  logic                       prev_clk_en,
   output logic                       clk_en,
   input  logic                       prev_stall,
   output logic                       stall,
   input  logic                       prev_flush,
   output logic                       flush
);
   state_t                     r_state;
   logic [4:0]                 r_rd, r_l_rd;
   logic [31:0]                r_rd_wdata, r_l_rd_wdata, r_pc, r_l_pc, r_wdata;
   logic                       r_rd_w_en, r_l_rd_w_en, r_rd_valid, r_clk_en;
   logic [EXCEPTION_WIDTH-1:0] r_exception, r_l_exception;
   logic [OPCODE_WIDTH-1:0]    r_opcode_type, r_l_opcode_type;
   logic [2:0]                 r_funct3, r_l_funct3;
   logic [1:0]                 r_l_off;
   logic                       r_l_load, r_flushed, r_req, r_we;
   logic [DMEM_AW-1:0]         r_addr;
   logic [3:0]                 r_sel;

   logic                       w_is_load, w_is_store, w_is_mem, w_trap, w_enter, w_stall, w_busy;
   logic [2:0]                 w_f3;
   logic [1:0]                 w_off;
   logic [3:0]                 w_sel;
   logic [31:0]                w_wdata, w_ldata;
   logic [EXCEPTION_WIDTH-1:0] w_trap_exc;

   assign w_is_load  = prev_opcode_type[OP_LOAD];
   assign w_is_store = prev_opcode_type[OP_STORE];
   assign w_is_mem   = w_is_load | w_is_store;
   assign w_busy     = (r_state == BUSY);

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_trap = w_is_mem & is_misaligned(prev_funct3, prev_alu_result[1:0]);
`else
   assign w_trap = 1'b0;
`endif

   always_comb begin
      w_trap_exc = '0;
      w_trap_exc[LOAD_ADDR_MISALIGNED]  = w_trap & ~w_is_store;
      w_trap_exc[STORE_ADDR_MISALIGNED] = w_trap & w_is_store;
   end

   // In IDLE the stage's own stall is just prev_stall, so gating entry on prev_stall
   // alone avoids a combinational loop through stall.
   assign w_enter = ~w_busy & prev_clk_en & ~prev_stall & ~prev_flush & w_is_mem & ~w_trap;
   assign w_stall = (w_busy & ~dmem.dmem_ack) | w_enter | prev_stall;
   assign stall   = w_stall;
   assign flush   = prev_flush;

   // One aligner serves both phases: store steering while IDLE, load extraction while BUSY.
   assign w_f3  = w_busy ? r_l_funct3 : prev_funct3;
   assign w_off = w_busy ? r_l_off : lane_offset(prev_funct3, prev_alu_result[1:0]);

   mem_lane_align u_align (
      .i_funct3 (w_f3),
      .i_off    (w_off),
      .i_rs2    (prev_rs2_data),
      .i_rdata  (dmem.dmem_rdata),
      .o_sel    (w_sel),
      .o_wdata  (w_wdata),
      .o_ldata  (w_ldata)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_rd <= '0; r_rd_wdata <= '0; r_rd_w_en <= 1'b0; r_rd_valid <= 1'b0;
         r_exception <= '0; r_opcode_type <= '0; r_funct3 <= '0; r_pc <= '0; r_clk_en <= 1'b0;
         r_req <= 1'b0; r_we <= 1'b0; r_addr <= '0; r_sel <= '0; r_wdata <= '0;
         r_l_rd <= '0; r_l_rd_wdata <= '0; r_l_rd_w_en <= 1'b0; r_l_exception <= '0;
         r_l_opcode_type <= '0; r_l_funct3 <= '0; r_l_off <= '0; r_l_pc <= '0;
         r_l_load <= 1'b0; r_flushed <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_enter) begin
                  r_state         <= BUSY;
                  r_req           <= 1'b1;
                  r_we            <= w_is_store;
                  r_addr          <= DMEM_AW'({prev_alu_result[31:2], 2'b00});
                  r_sel           <= w_sel;
                  r_wdata         <= w_wdata;
                  r_l_opcode_type <= prev_opcode_type;
                  r_l_funct3      <= prev_funct3;
                  r_l_off         <= w_off;
                  r_l_rd          <= prev_rd;
                  r_l_rd_wdata    <= prev_rd_wdata;
                  r_l_rd_w_en     <= prev_rd_w_en & w_is_load;
                  r_l_exception   <= prev_exception;
                  r_l_pc          <= prev_pc;
                  r_l_load        <= w_is_load;
                  r_flushed       <= 1'b0;
                  r_clk_en        <= 1'b0;
               end else if (!w_stall) begin
                  r_clk_en <= prev_clk_en & ~prev_flush;
                  if (prev_clk_en) begin
                     r_rd          <= prev_rd;
                     r_rd_wdata    <= prev_rd_wdata;
                     r_rd_w_en     <= prev_rd_w_en & ~w_is_store & ~w_trap;
                     r_rd_valid    <= prev_rd_valid;
                     r_exception   <= prev_exception | w_trap_exc;
                     r_opcode_type <= prev_opcode_type;
                     r_funct3      <= prev_funct3;
                     r_pc          <= prev_pc;
                  end
               end
            end
            BUSY: begin
               // A flush mid-transaction lets the bus cycle finish but discards its result.
               if (prev_flush) r_flushed <= 1'b1;
               if (dmem.dmem_ack) begin
                  r_state       <= IDLE;
                  r_req         <= 1'b0;
                  r_clk_en      <= ~(r_flushed | prev_flush);
                  r_rd          <= r_l_rd;
                  r_rd_wdata    <= r_l_load ? w_ldata : r_l_rd_wdata;
                  r_rd_w_en     <= r_l_rd_w_en;
                  r_rd_valid    <= r_l_load;
                  r_exception   <= r_l_exception;
                  r_opcode_type <= r_l_opcode_type;
                  r_funct3      <= r_l_funct3;
                  r_pc          <= r_l_pc;
               end else if (!prev_stall) begin
                  r_clk_en <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rd               = r_rd;
   assign rd_wdata         = r_rd_wdata;
   assign rd_w_en          = r_rd_w_en;
   assign rd_valid         = r_rd_valid;
   assign exception        = r_exception;
   assign opcode_type      = r_opcode_type;
   assign funct3           = r_funct3;
   assign pc               = r_pc;
   assign clk_en           = r_clk_en;
   assign dmem.dmem_req    = r_req;
   assign dmem.dmem_we     = r_we;
   assign dmem.dmem_addr   = r_addr;
   assign dmem.dmem_wdata  = r_wdata;
   assign dmem.dmem_sel    = r_sel;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: reset, store/load lane steering, back-to-back issue,
// flush and reset during a bus cycle, and misaligned word access (both macro builds).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_access;
   import mem_access_pkg::*;

   logic                       clk = 1'b0;
   logic                       rstn;
   logic [OPCODE_WIDTH-1:0]    prev_opcode_type, opcode_type;
   logic [2:0]                 prev_funct3, funct3;
   logic [31:0]                prev_alu_result, prev_rs2_data, prev_rd_wdata, prev_pc;
   logic [4:0]                 prev_rd, rd;
   logic                       prev_rd_w_en, prev_rd_valid;
   logic [EXCEPTION_WIDTH-1:0] prev_exception, exception;
   logic [31:0]                rd_wdata, pc;
   logic                       rd_w_en, rd_valid;
   logic                       prev_clk_en, clk_en, prev_stall, stall, prev_flush, flush;

   mem_access_if #(.DMEM_AW(32)) dmem_if ();

   mem_access #(.DMEM_AW(32)) dut (
      .clk(clk), .rstn(rstn),
      .prev_opcode_type(prev_opcode_type), .prev_funct3(prev_funct3),
      .prev_alu_result(prev_alu_result), .prev_rs2_data(prev_rs2_data),
      .prev_rd(prev_rd), .prev_rd_wdata(prev_rd_wdata), .prev_rd_w_en(prev_rd_w_en),
      .prev_rd_valid(prev_rd_valid), .prev_exception(prev_exception), .prev_pc(prev_pc),
      .rd(rd), .rd_wdata(rd_wdata), .rd_w_en(rd_w_en), .rd_valid(rd_valid),
      .exception(exception), .opcode_type(opcode_type), .funct3(funct3), .pc(pc),
      .dmem(dmem_if),
      .prev_clk_en(prev_clk_en), .clk_en(clk_en), .prev_stall(prev_stall), .stall(stall),
      .prev_flush(prev_flush), .flush(flush)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   int          obs_stall, obs_req;
   logic        obs_we, obs_busy_clk_en;
   logic [3:0]  obs_sel;
   logic [31:0] obs_addr, obs_wdata;

   function automatic logic [OPCODE_WIDTH-1:0] onehot(input int idx);
      logic [OPCODE_WIDTH-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   task automatic drive(input int op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] wdat);
      prev_clk_en      = 1'b1;
      prev_opcode_type = onehot(op);
      prev_funct3      = f3;
      prev_alu_result  = addr;
      prev_rs2_data    = rs2;
      prev_rd          = 5'd7;
      prev_rd_wdata    = wdat;
      prev_rd_w_en     = 1'b1;
      prev_rd_valid    = 1'b1;
      prev_exception   = '0;
      prev_pc          = 32'h0000_1000;
   endtask

   // Issues one memory instruction, holds it (upstream frozen) until ack after 'waits'
   // wait cycles, then leaves the sampling point on the cycle after ack.
   task automatic run_mem(input int op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input int waits, input logic [31:0] rdata,
                          input int flush_c);
      obs_stall = 0; obs_req = 0; obs_busy_clk_en = 1'b0;
      @(posedge clk); #1;
      drive(op, f3, addr, rs2, 32'h0);
      dmem_if.dmem_ack = 1'b0;
      @(negedge clk);
      if (stall) obs_stall++;
      for (int c = 1; c <= waits + 1; c++) begin
         @(posedge clk); #1;
         prev_flush         = (c == flush_c);
         dmem_if.dmem_ack   = (c == waits + 1);
         dmem_if.dmem_rdata = (c == waits + 1) ? rdata : 32'h0;
         @(negedge clk);
         if (stall) obs_stall++;
         if (dmem_if.dmem_req) obs_req++;
         if (clk_en) obs_busy_clk_en = 1'b1;
         if (c == 1) begin
            obs_addr = dmem_if.dmem_addr; obs_sel = dmem_if.dmem_sel;
            obs_wdata = dmem_if.dmem_wdata; obs_we = dmem_if.dmem_we;
         end
      end
      @(posedge clk); #1;
      prev_clk_en = 1'b0; prev_flush = 1'b0; dmem_if.dmem_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (dmem_if.dmem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", dmem_if.dmem_req); else n_pass++;
      n_checks++; if (clk_en !== 1'b0) $display("FAIL rst_clk_en: got %b want 0", clk_en); else n_pass++;
      n_checks++; if (rd_wdata !== 32'h0) $display("FAIL rst_rd_wdata: got %h want 0", rd_wdata); else n_pass++;
      n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
      @(posedge clk); #1;
      rstn = 1'b1;
   endtask

   task automatic test_store_word;
      run_mem(OP_STORE, SW, 32'h0000_0104, 32'hDEAD_BEEF, 3, 32'h0, 0);
      n_checks++; if (obs_addr !== 32'h104) $display("FAIL sw_addr: got %h want 104", obs_addr); else n_pass++;
      n_checks++; if (obs_sel !== 4'b1111) $display("FAIL sw_sel: got %b want 1111", obs_sel); else n_pass++;
      n_checks++; if (obs_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_wdata: got %h want deadbeef", obs_wdata); else n_pass++;
      n_checks++; if (obs_we !== 1'b1) $display("FAIL sw_we: got %b want 1", obs_we); else n_pass++;
      n_checks++; if (obs_stall !== 4) $display("FAIL sw_stall_cycles: got %0d want 4", obs_stall); else n_pass++;
      n_checks++; if (obs_req !== 4) $display("FAIL sw_req_cycles: got %0d want 4", obs_req); else n_pass++;
      n_checks++; if (rd_w_en !== 1'b0) $display("FAIL sw_rd_w_en: got %b want 0", rd_w_en); else n_pass++;
      n_checks++; if (clk_en !== 1'b1) $display("FAIL sw_clk_en: got %b want 1", clk_en); else n_pass++;
   endtask

   task automatic test_byte;
      run_mem(OP_LOAD, LB, 32'h0000_0203, 32'h0, 1, 32'h80FF_1122, 0);
      n_checks++; if (obs_sel !== 4'b1000) $display("FAIL lb_sel: got %b want 1000", obs_sel); else n_pass++;
      n_checks++; if (rd_wdata !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", rd_wdata); else n_pass++;
      n_checks++; if (rd_valid !== 1'b1) $display("FAIL lb_valid: got %b want 1", rd_valid); else n_pass++;
      run_mem(OP_LOAD, LBU, 32'h0000_0203, 32'h0, 0, 32'h80FF_1122, 0);
      n_checks++; if (rd_wdata !== 32'h0000_0080) $display("FAIL lbu_data: got %h want 00000080", rd_wdata); else n_pass++;
   endtask

   task automatic test_half;
      run_mem(OP_STORE, SH, 32'h0000_0302, 32'h0000_ABCD, 0, 32'h0, 0);
      n_checks++; if (obs_sel !== 4'b1100) $display("FAIL sh_sel: got %b want 1100", obs_sel); else n_pass++;
      n_checks++; if (obs_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata: got %h want abcdabcd", obs_wdata); else n_pass++;
      run_mem(OP_LOAD, LH, 32'h0000_0302, 32'h0, 2, 32'h7FFF_0000, 0);
      n_checks++; if (rd_wdata !== 32'h0000_7FFF) $display("FAIL lh_data: got %h want 00007fff", rd_wdata); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int req_cycles;
      req_cycles = 0;
      @(posedge clk); #1;
      drive(OP_ALU, 3'b000, 32'h5, 32'h0, 32'h5);
      @(negedge clk);
      @(posedge clk); #1;
      drive(OP_LOAD, LW, 32'h0000_0010, 32'h0, 32'h0);
      @(negedge clk);
      n_checks++; if (clk_en !== 1'b1) $display("FAIL b2b_add_clk_en: got %b want 1", clk_en); else n_pass++;
      n_checks++; if (rd_wdata !== 32'h5) $display("FAIL b2b_add_data: got %h want 5", rd_wdata); else n_pass++;
      n_checks++; if (stall !== 1'b1) $display("FAIL b2b_lw_stall: got %b want 1", stall); else n_pass++;
      @(posedge clk); #1;
      dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 32'h1234_5678;
      @(negedge clk);
      if (dmem_if.dmem_req) req_cycles++;
      n_checks++; if (clk_en !== 1'b0) $display("FAIL b2b_bubble: got %b want 0", clk_en); else n_pass++;
      @(posedge clk); #1;
      dmem_if.dmem_ack = 1'b0; prev_clk_en = 1'b0;
      @(negedge clk);
      if (dmem_if.dmem_req) req_cycles++;
      n_checks++; if (req_cycles !== 1) $display("FAIL b2b_req_cycles: got %0d want 1", req_cycles); else n_pass++;
      n_checks++; if (clk_en !== 1'b1) $display("FAIL b2b_lw_clk_en: got %b want 1", clk_en); else n_pass++;
      n_checks++; if (rd_wdata !== 32'h1234_5678) $display("FAIL b2b_lw_data: got %h want 12345678", rd_wdata); else n_pass++;
   endtask

   task automatic test_flush_busy;
      run_mem(OP_LOAD, LW, 32'h0000_0020, 32'h0, 2, 32'hCAFE_F00D, 1);
      n_checks++; if (obs_req !== 3) $display("FAIL flush_req_cycles: got %0d want 3", obs_req); else n_pass++;
      n_checks++; if (obs_busy_clk_en !== 1'b0) $display("FAIL flush_busy_clk_en: got %b want 0", obs_busy_clk_en); else n_pass++;
      n_checks++; if (clk_en !== 1'b0) $display("FAIL flush_clk_en: got %b want 0", clk_en); else n_pass++;
   endtask

   task automatic test_reset_busy;
      @(posedge clk); #1;
      drive(OP_LOAD, LW, 32'h0000_0040, 32'h0, 32'h0);
      @(posedge clk); #1;
      n_checks++; if (dmem_if.dmem_req !== 1'b1) $display("FAIL rstb_req_before: got %b want 1", dmem_if.dmem_req); else n_pass++;
      rstn = 1'b0; prev_clk_en = 1'b0;
      #1;
      n_checks++; if (dmem_if.dmem_req !== 1'b0) $display("FAIL rstb_req: got %b want 0", dmem_if.dmem_req); else n_pass++;
      n_checks++; if (dut.r_state !== IDLE) $display("FAIL rstb_state: got %0d want IDLE", dut.r_state); else n_pass++;
      @(posedge clk); #1;
      rstn = 1'b1;
   endtask

   task automatic test_misaligned;
`ifdef MEM_MISALIGN_TRAP_EN
      @(posedge clk); #1;
      drive(OP_LOAD, LW, 32'h0000_0101, 32'h0, 32'h0);
      @(negedge clk);
      n_checks++; if (stall !== 1'b0) $display("FAIL mis_stall: got %b want 0", stall); else n_pass++;
      @(posedge clk); #1;
      prev_clk_en = 1'b0;
      @(negedge clk);
      n_checks++; if (dmem_if.dmem_req !== 1'b0) $display("FAIL mis_req: got %b want 0", dmem_if.dmem_req); else n_pass++;
      n_checks++; if (exception[LOAD_ADDR_MISALIGNED] !== 1'b1) $display("FAIL mis_exc: got %b want 1", exception[LOAD_ADDR_MISALIGNED]); else n_pass++;
      n_checks++; if (rd_w_en !== 1'b0) $display("FAIL mis_rd_w_en: got %b want 0", rd_w_en); else n_pass++;
      n_checks++; if (clk_en !== 1'b1) $display("FAIL mis_clk_en: got %b want 1", clk_en); else n_pass++;
`else
      run_mem(OP_LOAD, LW, 32'h0000_0101, 32'h0, 0, 32'h0000_0055, 0);
      n_checks++; if (obs_addr !== 32'h100) $display("FAIL mis_addr: got %h want 100", obs_addr); else n_pass++;
      n_checks++; if (obs_sel !== 4'b1111) $display("FAIL mis_sel: got %b want 1111", obs_sel); else n_pass++;
      n_checks++; if (exception !== '0) $display("FAIL mis_exc: got %b want 0", exception); else n_pass++;
      n_checks++; if (rd_wdata !== 32'h55) $display("FAIL mis_data: got %h want 55", rd_wdata); else n_pass++;
`endif
   endtask

   initial begin
      rstn = 1'b0;
      prev_opcode_type = '0; prev_funct3 = '0; prev_alu_result = '0; prev_rs2_data = '0;
      prev_rd = '0; prev_rd_wdata = '0; prev_rd_w_en = 1'b0; prev_rd_valid = 1'b0;
      prev_exception = '0; prev_pc = '0; prev_clk_en = 1'b0; prev_stall = 1'b0; prev_flush = 1'b0;
      dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = '0;
      test_reset();
      test_store_word();
      test_byte();
      test_half();
      test_back_to_back();
      test_flush_busy();
      test_reset_busy();
      test_misaligned();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of writeback.
- Consumes the execute stage's registered outputs: alu_result, rs2_data, funct3, opcode_type, rd, rd_wdata, rd_valid, rd_w_en, exception, pc and stall_from_alu.
- For LOAD/STORE it runs a single-outstanding request/ack transaction on the data-memory port, steering byte lanes and sign-extending load data.
- All other instructions pass through with one cycle of latency.

Parameters:
- DMEM_AW, 32, width of the data-memory byte address (dmem_addr is word-aligned within it).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- prev_opcode_type  in  `OPCODE_WIDTH  one-hot opcode from execute
- prev_funct3  in  3  load/store size and sign
- prev_alu_result  in  32  effective address, or result passthrough
- prev_rs2_data  in  32  store data
- prev_rd  in  5  destination register address
- prev_rd_wdata  in  32  writeback data from execute
- prev_rd_w_en  in  1  writeback enable from execute
- prev_rd_valid  in  1  writeback data valid from execute
- prev_exception  in  `EXCEPTION_WIDTH  exception vector from execute
- prev_pc  in  32  instruction PC
- rd, rd_wdata, rd_w_en, rd_valid, exception, opcode_type, funct3, pc  out  (widths as inputs)  registered to writeback
- dmem_req  out  1  request strobe; held high until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  DMEM_AW  word address, low two bits 0
- dmem_wdata  out  32  lane-shifted store data
- dmem_sel  out  4  byte enables
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  32  load word, valid with ack
- prev_clk_en  in  1  upstream stage valid
- clk_en  out  1  this stage valid to writeback
- prev_stall  in  1  downstream stall
- stall  out  1  stall upstream stages
- prev_flush  in  1  flush request
- flush  out  1  flush propagated to upstream stages

Behaviour:
- Reset: all outputs are 0; FSM is in IDLE.
- Reset mid-transaction: request is dropped immediately; no wait for ack.
- FSM states are IDLE and BUSY.
- IDLE -> BUSY when all hold: prev_clk_en=1, stall_bit=0, prev_flush=0, opcode is LOAD or STORE.
  - stall_bit = prev_stall | stall.
  - On entry, latch addr, sel, wdata and we, and assert dmem_req in the next cycle.
  - Exception: with MEM_MISALIGN_TRAP_EN compiled in, a misaligned access does not enter BUSY (see Optional Feature).
- BUSY:
  - dmem_req, dmem_addr, dmem_sel, dmem_wdata and dmem_we are stable until dmem_ack.
  - On ack, return to IDLE and register stage outputs.
  - For a load, rd_wdata = extracted data and rd_valid = 1.
  - clk_en = 1 on the following cycle.
- stall = (state==BUSY & !dmem_ack) | (state==IDLE & entering BUSY) | prev_stall.
- Upstream stays frozen for the whole transaction.
- Latency:
  - Non-memory instructions: 1 cycle.
  - Memory instructions: 2 + W cycles, where W is the number of wait cycles before ack.
- Byte-lane steering for funct3 LB/LBU/SB:
  - sel = 0001 << addr[1:0].
  - wdata = {4{rs2[7:0]}}.
  - Load data = rdata byte addr[1:0]; LB sign-extends, LBU zero-extends.
- Byte-lane steering for funct3 LH/LHU/SH:
  - sel = 0011 << {addr[1],1'b0}.
  - wdata = {2{rs2[15:0]}}.
  - Load data = halfword addr[1]; sign or zero extension as for bytes.
- Byte-lane steering for funct3 LW/SW: sel = 1111.
- Stores: rd_w_en = 0.
- Pass-through instructions: all prev_* fields are registered when stall_bit=0 and prev_clk_en=1.
- clk_en rules, same as the other stages:
  - Flush with no stall -> 0.
  - No stall -> prev_clk_en.
  - Stalled while downstream is not stalled -> 0 (bubble).
- flush = prev_flush, combinational.
- A flush that arrives during BUSY does not abort the bus cycle: the transaction completes, its result is discarded, and clk_en = 0.
- dmem_ack while in IDLE is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Compiled in:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, issues no request.
  - Sets `LOAD_ADDR_MISALIGNED or `STORE_ADDR_MISALIGNED in the exception output.
  - rd_w_en = 0; latency is 1 cycle.
- Compiled out:
  - Low address bits are ignored for the access width, i.e. the access is forced aligned.
  - No exception is raised.

Decomposition:
- rv32i_header.vh gains:
  - funct3 load/store constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - Exception bit indices `LOAD_ADDR_MISALIGNED and `STORE_ADDR_MISALIGNED.
- Opcode and exception widths are reused from the header.
- One sub-module, mem_lane_align: combinational sel/wdata generation and load extract/extend.

Test Plan:
- SW of rs2=0xDEADBEEF at addr 0x104, ack after 3 waits -> dmem_addr=0x104, sel=1111, wdata=0xDEADBEEF, rd_w_en=0, stall high for 4 cycles.
- LB from addr 0x203 with rdata=0x80FF1122 -> sel=1000, rd_wdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH of rs2=0x0000ABCD at addr 0x302 -> sel=1100, wdata=0xABCDABCD. LH from the same address with rdata=0x7FFF0000 -> rd_wdata=0x00007FFF.
- Back-to-back ADD result 5 then LW with 0 waits -> ADD arrives at writeback after 1 cycle; LW asserts req for 1 cycle and clk_en rises 2 cycles after issue.
- prev_flush during BUSY, then ack -> bus completes and clk_en=0. rstn low during BUSY -> dmem_req=0 immediately and FSM in IDLE.
- LW at addr 0x101:
  - With MEM_MISALIGN_TRAP_EN -> no dmem_req, `LOAD_ADDR_MISALIGNED set.
  - Without it -> dmem_addr=0x100, sel=1111.
